// File: rtl/sccb_write_master.sv
// sccb_write_master: 3-phase SCCB write master for camera register config.
// Takes one {reg,value} word, sends ID/reg/value with START/STOP, pulses sccb_ok.
module sccb_write_master #(
  parameter int         CLK_DIV  = 250,
  parameter logic [7:0] DEV_ADDR = 8'h60,
  parameter int         GAP_Q    = 4,
  parameter int         RST_WAIT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cfg_data,
  input  logic        cfg_valid,
  output logic        sccb_ok,
  output logic        busy,
  output logic        sioc,
  output logic        siod_out,
  output logic        siod_oe
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP_Q + 1);
  localparam int WW = $clog2(RST_WAIT + 2);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_OK    = CW'(CLK_DIV - 2);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_Q - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RST_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BITS,
    S_STOP,
    S_RSTW,
    S_GAP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    qtr_q;
  logic [3:0]    bit_q;
  logic [1:0]    byte_q;
  logic [GW-1:0] gap_q;
  logic [WW-1:0] wait_q;
  logic [23:0]   sr_q;
  logic          soft_q;
  logic          sioc_q;
  logic          siod_q;
  logic          oe_q;
  logic          ok_q;
  logic          busy_q;

  logic          tick;
  logic [23:0]   sr_shift;

  assign tick     = (cnt_q == CNT_LAST);
  assign sr_shift = {sr_q[22:0], 1'b0};

  assign sccb_ok  = ok_q;
  assign busy     = busy_q;
  assign sioc     = sioc_q;
  assign siod_out = siod_q;
  assign siod_oe  = oe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      gap_q   <= '0;
      wait_q  <= '0;
      sr_q    <= '0;
      soft_q  <= 1'b0;
      sioc_q  <= 1'b1;
      siod_q  <= 1'b1;
      oe_q    <= 1'b1;
      ok_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ok_q <= 1'b0;
      if (state_q != S_IDLE) begin
        cnt_q <= tick ? '0 : cnt_q + 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            sr_q    <= {DEV_ADDR, cfg_data};
            soft_q  <= (cfg_data[15:8] == 8'h12)
                       && cfg_data[7];
            busy_q  <= 1'b1;
            sioc_q  <= 1'b1;
            siod_q  <= 1'b0;
            oe_q    <= 1'b1;
            qtr_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (qtr_q[0]) begin
              state_q <= S_BITS;
              qtr_q   <= '0;
              bit_q   <= '0;
              byte_q  <= '0;
              sioc_q  <= 1'b0;
              siod_q  <= sr_q[23];
              sr_q    <= sr_shift;
            end else begin
              qtr_q <= qtr_q + 1'b1;
            end
          end
        end
        S_BITS: begin
          if (tick) begin
            qtr_q <= qtr_q + 1'b1;
            if (qtr_q == 2'd1) begin
              sioc_q <= 1'b1;
            end
            if (qtr_q == 2'd3) begin
              sioc_q <= 1'b0;
              if (bit_q == 4'd8) begin
                bit_q <= '0;
                oe_q  <= 1'b1;
                if (byte_q == 2'd2) begin
                  state_q <= S_STOP;
                  siod_q  <= 1'b0;
                end else begin
                  byte_q <= byte_q + 1'b1;
                  siod_q <= sr_q[23];
                  sr_q   <= sr_shift;
                end
              end else begin
                bit_q <= bit_q + 1'b1;
                // ninth bit of each phase: release SIOD
                if (bit_q == 4'd7) begin
                  siod_q <= 1'b1;
                  oe_q   <= 1'b0;
                end else begin
                  siod_q <= sr_q[23];
                  sr_q   <= sr_shift;
                end
              end
            end
          end
        end
        S_STOP: begin
          if (qtr_q == 2'd3 && cnt_q == CNT_OK) begin
            ok_q <= 1'b1;
          end
          if (tick) begin
            qtr_q <= qtr_q + 1'b1;
            if (qtr_q == 2'd0) begin
              sioc_q <= 1'b1;
            end
            if (qtr_q == 2'd1) begin
              siod_q <= 1'b1;
            end
            if (qtr_q == 2'd3) begin
              gap_q   <= '0;
              wait_q  <= '0;
              state_q <= (soft_q && RST_WAIT > 0)
                         ? S_RSTW : S_GAP;
            end
          end
        end
        S_RSTW: begin
          if (wait_q == WAIT_LAST) begin
            state_q <= S_GAP;
            cnt_q   <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_GAP: begin
          if (tick) begin
            if (gap_q == GAP_LAST) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
